arb_req_client: RTL and testbench

//  Requester-side agent for the N-way round-robin arbiter. Each channel queues

---
 rtl/arb_req_client.sv | 164 ++++++++++++++++
 tb/tb_arb_req_client.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_client.sv
// arb_req_client
// Requester-side agent for an N-way round-robin arbiter. Each channel keeps a
// count of pending transaction tokens and holds its req line while that count
// is non-zero. Every grant it receives while requesting retires one token.
// The block also watches the arbiter's gnt stream and raises sticky error
// flags for these conditions:
//   - more than one grant bit set in the same cycle,
//   - a grant to a channel that is not requesting,
//   - a request that waits too long without being granted.
// It serves both as the arbiter's client in the design and as a protocol
// monitor in benches.

module arb_req_client #(
    parameter int n          = 3,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n:0]   push,
    input  logic [n:0]   gnt,
    input  logic         err_clr,
    output logic [n:0]   req,
    output logic [n:0]   done,
    output logic [n:0]   full,
    output logic [n:0]   drop,
    output logic         err_onehot,
    output logic         err_spur,
    output logic         err_starve
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);

    logic [CW-1:0] cnt_q  [0:n];
    logic [CW-1:0] cnt_d  [0:n];
    logic [WW-1:0] wait_q [0:n];
    logic [WW-1:0] wait_d [0:n];

    logic [n:0]    done_q;
    logic [n:0]    done_d;
    logic [n:0]    drop_q;
    logic [n:0]    drop_d;
    logic          err_onehot_q;
    logic          err_onehot_d;
    logic          err_spur_q;
    logic          err_spur_d;
    logic          err_starve_q;
    logic          err_starve_d;

    logic [n:0]    take;
    logic [n:0]    spur_hit;
    logic          multi_hit;
    logic          starve_hit;

    // req and full come only from the registered counts, so there is no
    // combinational path from push or gnt to the arbiter-facing outputs.
    always_comb begin
        req  = '0;
        full = '0;
        for (int i = 0; i <= n; i++) begin
            req[i]  = (cnt_q[i] != '0);
            full[i] = (cnt_q[i] == CNT_MAX);
        end
    end

    // A grant only retires a token when the channel is actually requesting.
    // A grant without a request is flagged as spurious and changes nothing.
    always_comb begin
        take      = gnt & req;
        spur_hit  = gnt & ~req;
        multi_hit = ($countones(gnt) > 1);
    end

    // Token count update:
    //   - push and take together cancel out, so a full channel still accepts
    //     the push in that case.
    //   - A push into a full channel that is not being granted is dropped.
    //   - done marks each retired token one cycle after its grant.
    always_comb begin
        drop_d = '0;
        done_d = take;
        for (int i = 0; i <= n; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !take[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    drop_d[i] = 1'b1;
                end
            end else if (!push[i] && take[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Per-channel wait counter measures how long a request has gone
    // unserved. It saturates so that a long stall never wraps back to a
    // small value.
    always_comb begin
        starve_hit = 1'b0;
        for (int i = 0; i <= n; i++) begin
            wait_d[i] = wait_q[i];
            if (!req[i] || take[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_MAX) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
            if (wait_d[i] == WAIT_MAX) begin
                starve_hit = 1'b1;
            end
        end
    end

    // Sticky error flags.
    // A clear takes priority over a new error detected in the same cycle,
    // so software sees a clean slate right after clearing.
    always_comb begin
        err_onehot_d = err_onehot_q | multi_hit;
        err_spur_d   = err_spur_q   | (|spur_hit);
        err_starve_d = err_starve_q | starve_hit;
        if (err_clr) begin
            err_onehot_d = 1'b0;
            err_spur_d   = 1'b0;
            err_starve_d = 1'b0;
        end
    end

    // State registers. Reset drops every pending token immediately, so req
    // and full fall as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= n; i++) begin
                cnt_q[i]  <= '0;
                wait_q[i] <= '0;
            end
            done_q       <= '0;
            drop_q       <= '0;
            err_onehot_q <= 1'b0;
            err_spur_q   <= 1'b0;
            err_starve_q <= 1'b0;
        end else begin
            for (int i = 0; i <= n; i++) begin
                cnt_q[i]  <= cnt_d[i];
                wait_q[i] <= wait_d[i];
            end
            done_q       <= done_d;
            drop_q       <= drop_d;
            err_onehot_q <= err_onehot_d;
            err_spur_q   <= err_spur_d;
            err_starve_q <= err_starve_d;
        end
    end

    assign done       = done_q;
    assign drop       = drop_q;
    assign err_onehot = err_onehot_q;
    assign err_spur   = err_spur_q;
    assign err_starve = err_starve_q;

endmodule

// File: tb/tb_arb_req_client.sv
// tb_arb_req_client
// Scenario tasks plus a randomized run for arb_req_client. Expected values
// come from a token-count model of each channel held in plain integers.

module tb_arb_req_client;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int SMAX  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] push = '0;
    logic [3:0] gnt = '0;
    logic       err_clr = 1'b0;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] full;
    logic [3:0] drop;
    logic       err_onehot;
    logic       err_spur;
    logic       err_starve;

    int checks   = 0;
    int failures = 0;

    int         mcnt  [N];
    int         mwait [N];
    logic [3:0] mdone;
    logic [3:0] mdrop;
    logic       m_onehot;
    logic       m_spur;
    logic       m_starve;

    arb_req_client #(.n(3), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .gnt        (gnt),
        .err_clr    (err_clr),
        .req        (req),
        .done       (done),
        .full       (full),
        .drop       (drop),
        .err_onehot (err_onehot),
        .err_spur   (err_spur),
        .err_starve (err_starve)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_req();
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = (mcnt[i] > 0);
        return r;
    endfunction

    function automatic logic [3:0] exp_full();
        logic [3:0] f;
        for (int i = 0; i < N; i++) f[i] = (mcnt[i] == DEPTH);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mcnt[i]  = 0;
            mwait[i] = 0;
        end
        mdone    = '0;
        mdrop    = '0;
        m_onehot = 1'b0;
        m_spur   = 1'b0;
        m_starve = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample at +1.
    task automatic tick(input logic [3:0] p, input logic [3:0] g, input logic c);
        logic [3:0] rv;
        logic       spur;
        logic       hit;
        logic       tk;
        push    = p;
        gnt     = g;
        err_clr = c;
        @(posedge clk);
        rv   = exp_req();
        spur = 1'b0;
        hit  = 1'b0;
        for (int i = 0; i < N; i++) begin
            tk = g[i] && rv[i];
            if (g[i] && !rv[i]) spur = 1'b1;
            mdone[i] = tk;
            mdrop[i] = 1'b0;
            if (p[i] && !tk) begin
                if (mcnt[i] < DEPTH) mcnt[i] = mcnt[i] + 1;
                else mdrop[i] = 1'b1;
            end else if (!p[i] && tk) begin
                mcnt[i] = mcnt[i] - 1;
            end
            if (!rv[i] || tk) mwait[i] = 0;
            else if (mwait[i] < SMAX) mwait[i] = mwait[i] + 1;
            if (mwait[i] >= SMAX) hit = 1'b1;
        end
        if (c) begin
            m_onehot = 1'b0;
            m_spur   = 1'b0;
            m_starve = 1'b0;
        end else begin
            m_onehot = m_onehot | ($countones(g) > 1);
            m_spur   = m_spur | spur;
            m_starve = m_starve | hit;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (req !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_req got=%b exp=0000", req);
        end
        checks++;
        if (done !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_done got=%b exp=0000", done);
        end
        checks++;
        if (full !== 4'b0000 || drop !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_full_drop got=%b/%b exp=0000/0000", full, drop);
        end
        checks++;
        if ({err_onehot, err_spur, err_starve} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_err got=%b exp=000", {err_onehot, err_spur, err_starve});
        end
    endtask

    task automatic test_single();
        tick(4'b0001, 4'b0000, 1'b0);
        checks++;
        if (req !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_req got=%b exp=0001", req);
        end
        tick(4'b0000, req, 1'b0);
        checks++;
        if (done !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_done got=%b exp=0001", done);
        end
        checks++;
        if (req !== exp_req()) begin
            failures++;
            $display("[TB] FAIL single_req_fall got=%b exp=%b", req, exp_req());
        end
        tick(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (done !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL single_done_pulse got=%b exp=0000", done);
        end
    endtask

    task automatic test_full_drop();
        for (int k = 0; k < DEPTH; k++) tick(4'b0100, 4'b0000, 1'b0);
        checks++;
        if (full !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL fill_full got=%b exp=0100", full);
        end
        tick(4'b0100, 4'b0000, 1'b0);
        checks++;
        if (drop !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL overflow_drop got=%b exp=0100", drop);
        end
        checks++;
        if (full !== exp_full()) begin
            failures++;
            $display("[TB] FAIL overflow_full got=%b exp=%b", full, exp_full());
        end
        for (int k = 0; k < DEPTH; k++) begin
            tick(4'b0000, 4'b0100, 1'b0);
            checks++;
            if (done !== 4'b0100 || drop !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL drain_done k=%0d got=%b/%b exp=0100/0000", k, done, drop);
            end
        end
        checks++;
        if (req !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL drain_req got=%b exp=0000", req);
        end
    endtask

    task automatic test_full_push_take();
        for (int k = 0; k < DEPTH; k++) tick(4'b0010, 4'b0000, 1'b0);
        tick(4'b0010, 4'b0010, 1'b0);
        checks++;
        if (full !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL pushtake_full got=%b exp=0010", full);
        end
        checks++;
        if (drop !== 4'b0000 || done !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL pushtake_drop_done got=%b/%b exp=0000/0010", drop, done);
        end
        for (int k = 0; k < DEPTH; k++) tick(4'b0000, 4'b0010, 1'b0);
        checks++;
        if (req !== exp_req()) begin
            failures++;
            $display("[TB] FAIL pushtake_drain got=%b exp=%b", req, exp_req());
        end
    endtask

    task automatic test_errors();
        tick(4'b0001, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0011, 1'b0);
        checks++;
        if (err_onehot !== 1'b1 || err_spur !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_set got=%b%b exp=11", err_onehot, err_spur);
        end
        checks++;
        if (req !== 4'b0000 || done !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL err_take got=%b/%b exp=0000/0001", req, done);
        end
        tick(4'b0000, 4'b0000, 1'b1);
        checks++;
        if (err_onehot !== 1'b0 || err_spur !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_clear got=%b%b exp=00", err_onehot, err_spur);
        end
        tick(4'b0000, 4'b0011, 1'b1);
        checks++;
        if ({err_onehot, err_spur} !== {m_onehot, m_spur}) begin
            failures++;
            $display("[TB] FAIL err_clr_wins got=%b%b exp=%b%b", err_onehot, err_spur, m_onehot, m_spur);
        end
        checks++;
        if (req !== 4'b0000 || done !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL spur_no_change got=%b/%b exp=0000/0000", req, done);
        end
    endtask

    task automatic test_starve();
        tick(4'b1111, 4'b0000, 1'b0);
        for (int k = 0; k < SMAX + 3; k++) begin
            tick(4'b0001, 4'b0001, 1'b0);
            checks++;
            if (err_starve !== m_starve || req !== exp_req()) begin
                failures++;
                $display("[TB] FAIL starve k=%0d got=%b/%b exp=%b/%b", k, err_starve, req, m_starve, exp_req());
            end
        end
        checks++;
        if (err_starve !== 1'b1) begin
            failures++;
            $display("[TB] FAIL starve_final got=%b exp=1", err_starve);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (req !== 4'b0000 || err_starve !== 1'b0 || done !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL async_reset got=%b/%b/%b exp=0000/0/0000", req, err_starve, done);
        end
        push = '0;
        gnt  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (req !== 4'b0000 || done !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL post_reset got=%b/%b exp=0000/0000", req, done);
        end
    endtask

    task automatic test_random();
        logic [3:0] p;
        logic [3:0] g;
        logic       c;
        int         mode;
        for (int k = 0; k < 300; k++) begin
            p    = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 9);
            if (mode < 6) g = exp_req() & (4'b0001 << $urandom_range(0, 3));
            else if (mode < 8) g = 4'($urandom_range(0, 15));
            else g = 4'b0000;
            c = ($urandom_range(0, 15) == 0);
            tick(p, g, c);
            checks++;
            if (req !== exp_req() || full !== exp_full()) begin
                failures++;
                $display("[TB] FAIL rand_req_full k=%0d got=%b/%b exp=%b/%b", k, req, full, exp_req(), exp_full());
            end
            checks++;
            if (done !== mdone || drop !== mdrop) begin
                failures++;
                $display("[TB] FAIL rand_done_drop k=%0d got=%b/%b exp=%b/%b", k, done, drop, mdone, mdrop);
            end
            checks++;
            if ({err_onehot, err_spur, err_starve} !== {m_onehot, m_spur, m_starve}) begin
                failures++;
                $display("[TB] FAIL rand_err k=%0d got=%b exp=%b", k, {err_onehot, err_spur, err_starve},
                         {m_onehot, m_spur, m_starve});
            end
        end
    endtask

    // Scenario sequence followed by the randomized run.
    initial begin
        model_reset();
        test_reset();
        test_single();
        test_full_drop();
        test_full_push_take();
        test_errors();
        test_starve();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
